uart_boot_ctrl: RTL

- Sequences the single-cycle RV32 core at power-up.
- Holds the core in reset while a program image arrives byte-by-byte from the UART receiver.
- Assembles the bytes into 32-bit words, writes them into instruction memory and validates a checksum.
- Answers the host through the UART transmitter, then releases the core to execute from address 0.
- Sits between the UART RX/TX blocks, the instruction memory write port and the core's `rst_n` input.

---
 rtl/uart_boot_ctrl.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_boot_ctrl.sv
// UART boot loader: receives a framed image, writes it into IMEM and releases the core after ACK.
// Define BOOT_CSUM_EN to expect and check a trailing XOR checksum byte.
module uart_boot_ctrl #(
    parameter int IMEM_DEPTH     = 1024,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_rst_n,
    output logic        boot_done,
    output logic        boot_err
);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [16:0] DEPTH = 17'(IMEM_DEPTH);
    localparam logic [7:0] SYNC = 8'hA5;
    localparam logic [7:0] ACK  = 8'h06;
    localparam logic [7:0] NAK  = 8'h15;

`ifdef BOOT_CSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_RESP, S_RUN
    } state_e;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_RESP, S_RUN
    } state_e;
`endif

    state_e state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [15:0] word_cnt_q, word_cnt_d;
    logic [1:0] byte_cnt_q, byte_cnt_d;
    logic [23:0] shift_q, shift_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic ok_q, ok_d;
    logic err_q, err_d;
    logic we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [15:0] n_rx;
    logic in_load;
`ifdef BOOT_CSUM_EN
    logic [7:0] csum_q, csum_d;
`endif

    assign n_rx = {rx_data, len_q[7:0]};
`ifdef BOOT_CSUM_EN
    assign in_load = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                     (state_q == S_DATA) || (state_q == S_CSUM);
`else
    assign in_load = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                     (state_q == S_DATA);
`endif

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        tmo_d      = tmo_q;
        tx_data_d  = tx_data_q;
        ok_d       = ok_q;
        err_d      = err_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
`ifdef BOOT_CSUM_EN
        csum_d     = csum_q;
`endif
        // Inter-byte watchdog; any received byte restarts it
        if (in_load) begin
            if (rx_valid) begin
                tmo_d = '0;
            end else if (tmo_q == TMO_LAST) begin
                tmo_d   = '0;
                err_d   = 1'b1;
                state_d = S_IDLE;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
        unique case (state_q)
            S_IDLE: begin
                if (rx_valid && rx_data == SYNC) begin
                    err_d   = 1'b0;
                    tmo_d   = '0;
`ifdef BOOT_CSUM_EN
                    csum_d  = 8'h00;
`endif
                    state_d = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (rx_valid) begin
                    len_d[7:0] = rx_data;
                    state_d    = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (rx_valid) begin
                    len_d[15:8] = rx_data;
                    if (n_rx == 16'd0 || {1'b0, n_rx} > DEPTH) begin
                        tx_data_d = NAK;
                        ok_d      = 1'b0;
                        err_d     = 1'b1;
                        state_d   = S_RESP;
                    end else begin
                        byte_cnt_d = 2'd0;
                        word_cnt_d = 16'd0;
                        state_d    = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (rx_valid) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef BOOT_CSUM_EN
                    csum_d = csum_q ^ rx_data;
`endif
                    unique case (byte_cnt_q)
                        2'd0: shift_d[7:0]   = rx_data;
                        2'd1: shift_d[15:8]  = rx_data;
                        2'd2: shift_d[23:16] = rx_data;
                        default: begin
                            we_d       = 1'b1;
                            addr_d     = {14'd0, word_cnt_q, 2'b00};
                            wdata_d    = {rx_data, shift_q};
                            word_cnt_d = word_cnt_q + 16'd1;
                            if (word_cnt_q == len_q - 16'd1) begin
`ifdef BOOT_CSUM_EN
                                state_d = S_CSUM;
`else
                                tx_data_d = ACK;
                                ok_d      = 1'b1;
                                state_d   = S_RESP;
`endif
                            end
                        end
                    endcase
                end
            end
`ifdef BOOT_CSUM_EN
            S_CSUM: begin
                if (rx_valid) begin
                    if (rx_data == csum_q) begin
                        tx_data_d = ACK;
                        ok_d      = 1'b1;
                    end else begin
                        tx_data_d = NAK;
                        ok_d      = 1'b0;
                        err_d     = 1'b1;
                    end
                    state_d = S_RESP;
                end
            end
`endif
            S_RESP: begin
                if (tx_ready) state_d = ok_q ? S_RUN : S_IDLE;
            end
            S_RUN: ;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            tmo_q      <= '0;
            tx_data_q  <= '0;
            ok_q       <= 1'b0;
            err_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
`ifdef BOOT_CSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            tmo_q      <= tmo_d;
            tx_data_q  <= tx_data_d;
            ok_q       <= ok_d;
            err_q      <= err_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
`ifdef BOOT_CSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_valid   = (state_q == S_RESP);
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign core_rst_n = (state_q == S_RUN);
    assign boot_done  = (state_q == S_RUN);
    assign boot_err   = err_q;

endmodule
